// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised data memory with fixed-latency busywait handshake.
//   CLK                  rising-edge clock
//   RESET                synchronous active-high reset (storage contents preserved)
//   DATA_MEM_READ[3:0]   bit3 read request, bits2:0 load funct3
//   DATA_MEM_WRITE[2:0]  bit2 write request, bits1:0 store funct3
//   DATA_MEM_ADDR        byte address (wraps modulo the storage size)
//   DATA_MEM_WRITE_DATA  store data
//   DATA_MEM_READ_DATA   registered, extended load result
//   DATA_MEM_BUSYWAIT    high while an access is in progress
//   MISALIGNED           one-cycle pulse in DONE for an aborted misaligned access
module data_memory_responder #(
    parameter int ADDR_WIDTH     = 10,
    parameter int ACCESS_LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  DATA_MEM_READ,
    input  logic [2:0]  DATA_MEM_WRITE,
    input  logic [31:0] DATA_MEM_ADDR,
    input  logic [31:0] DATA_MEM_WRITE_DATA,
    output logic [31:0] DATA_MEM_READ_DATA,
    output logic        DATA_MEM_BUSYWAIT,
    output logic        MISALIGNED
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_LATENCY - 2);
    state_t r_state, w_next;
    logic [3:0] r_cnt;
    logic r_is_write, r_mis;
    logic [2:0] r_funct3;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [0:2**ADDR_WIDTH-1];
    logic w_req, w_start, w_commit, w_valid, w_misaligned, w_we, w_unused;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0] w_lane;
    logic [31:0] w_word, w_load, w_wdata;
    logic [7:0] w_byte;
    logic [15:0] w_half;
    logic [3:0] w_wmask;
    assign w_unused = &{1'b0, DATA_MEM_ADDR[31:ADDR_WIDTH+2]};
    assign w_req = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];
    assign w_start = (r_state == IDLE) && w_req;
    assign w_commit = (r_state == ACCESS) && (r_cnt == 4'd0);
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)   ? (w_req ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? ((r_cnt == 4'd0) ? DONE : ACCESS) : IDLE;
    end
    always_comb begin
        DATA_MEM_BUSYWAIT = !RESET && (w_start || (r_state == ACCESS));
        MISALIGNED = r_mis;
    end
    // Undefined funct3: reads 011/110/111, writes 11 (latched as 011).
    assign w_valid = !(r_funct3[1] && (r_funct3[0] || r_funct3[2]));
    assign w_misaligned = w_valid && (((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                                      ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)));
    assign w_idx = r_addr[ADDR_WIDTH+1:2];
    assign w_lane = r_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
    // funct3[2] selects zero-extension for LBU/LHU.
    assign w_load = (!w_valid || w_misaligned) ? 32'd0 :
                    (r_funct3[1:0] == 2'b00) ? {{24{!r_funct3[2] & w_byte[7]}}, w_byte} :
                    (r_funct3[1:0] == 2'b01) ? {{16{!r_funct3[2] & w_half[15]}}, w_half} : w_word;
    assign w_we = !RESET && w_commit && r_is_write && w_valid && !w_misaligned;
    assign w_wmask = (r_funct3[1:0] == 2'b00) ? (4'b0001 << w_lane) :
                     (r_funct3[1:0] == 2'b01) ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = (r_funct3[1:0] == 2'b00) ? {4{r_wdata[7:0]}} :
                     (r_funct3[1:0] == 2'b01) ? {2{r_wdata[15:0]}} : r_wdata;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= 4'd0;
            r_mis <= 1'b0;
            DATA_MEM_READ_DATA <= 32'd0;
        end else begin
            r_mis <= w_commit && w_misaligned;
            if (w_start) begin
                r_cnt <= CNT_INIT;
                r_is_write <= DATA_MEM_WRITE[2];
                r_funct3 <= DATA_MEM_WRITE[2] ? {1'b0, DATA_MEM_WRITE[1:0]} : DATA_MEM_READ[2:0];
                r_addr <= DATA_MEM_ADDR[ADDR_WIDTH+1:0];
                r_wdata <= DATA_MEM_WRITE_DATA;
            end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !r_is_write) DATA_MEM_READ_DATA <= w_load;
        end
    end
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++)
            if (w_we && w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: byte-array model plus per-cycle compare and literal pins.
module tb_data_memory_responder;
    localparam int AW = 10, LAT = 3, MB = 4 * (2 ** AW);
    logic CLK = 1'b0, RESET;
    logic [3:0] DATA_MEM_READ;
    logic [2:0] DATA_MEM_WRITE;
    logic [31:0] DATA_MEM_ADDR, DATA_MEM_WRITE_DATA, DATA_MEM_READ_DATA;
    logic DATA_MEM_BUSYWAIT, MISALIGNED;
    int n_cmp = 0, n_bad = 0, busy_cyc = 0, bursts = 0, mis_cyc = 0;
    logic prev_busy = 1'b0, chk_en = 1'b0, exp_busy = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [7:0] mb [0:MB-1];
    always #5 CLK = ~CLK;
    data_memory_responder #(.ADDR_WIDTH(AW), .ACCESS_LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
        .DATA_MEM_ADDR(DATA_MEM_ADDR), .DATA_MEM_WRITE_DATA(DATA_MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA(DATA_MEM_READ_DATA), .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
        .MISALIGNED(MISALIGNED));
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("busywait", 32'(DATA_MEM_BUSYWAIT), 32'(exp_busy));
            cmp("misaligned", 32'(MISALIGNED), 32'(exp_mis));
            cmp("read_data", DATA_MEM_READ_DATA, exp_rdata);
            if (DATA_MEM_BUSYWAIT && !prev_busy) bursts++;
            if (DATA_MEM_BUSYWAIT) busy_cyc++;
            if (MISALIGNED) mis_cyc++;
            prev_busy = DATA_MEM_BUSYWAIT;
        end
    end
    function automatic void st(input logic [1:0] f, input logic [31:0] a, input logic [31:0] d, output logic mis);
        int n;
        n = (f == 2'd0) ? 1 : (f == 2'd1) ? 2 : (f == 2'd2) ? 4 : 0;
        mis = 1'b0;
        if (n == 0) return;
        if ((a % n) != 0) begin
            mis = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) mb[(a + i) % MB] = d[8*i +: 8];
    endfunction
    function automatic logic [31:0] ld(input logic [2:0] f, input logic [31:0] a, output logic mis);
        int n;
        logic [31:0] v;
        n = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : (f == 3'd2) ? 4 : 0;
        mis = 1'b0;
        if (n == 0) return 32'd0;
        if ((a % n) != 0) begin
            mis = 1'b1;
            return 32'd0;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[(a + i) % MB];
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction
    // One complete access: request held through DONE, address/data scrambled while busy.
    task automatic acc(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        logic m;
        logic [31:0] v;
        DATA_MEM_READ = {r, f};
        DATA_MEM_WRITE = {w, f[1:0]};
        DATA_MEM_ADDR = a;
        DATA_MEM_WRITE_DATA = d;
        for (int k = 0; k < LAT; k++) begin
            exp_busy = 1'b1;
            @(posedge CLK); #1;
            DATA_MEM_ADDR = $urandom;
            DATA_MEM_WRITE_DATA = $urandom;
        end
        DATA_MEM_ADDR = a;
        DATA_MEM_WRITE_DATA = d;
        exp_busy = 1'b0;
        if (w) begin
            st(f[1:0], a, d, m);
            exp_mis = m;
        end else begin
            v = ld(f, a, m);
            exp_mis = m;
            exp_rdata = v;
        end
        @(posedge CLK); #1;
        DATA_MEM_READ = 4'd0;
        DATA_MEM_WRITE = 3'd0;
        exp_mis = 1'b0;
        @(posedge CLK); #1;
    endtask
    initial begin
        int b0;
        RESET = 1'b1;
        DATA_MEM_READ = 4'b1010;
        DATA_MEM_WRITE = 3'b110;
        DATA_MEM_ADDR = 32'h10;
        DATA_MEM_WRITE_DATA = 32'h1;
        @(posedge CLK); #1;
        chk_en = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        DATA_MEM_READ = 4'd0;
        DATA_MEM_WRITE = 3'd0;
        @(posedge CLK); #1;
        b0 = busy_cyc;
        acc(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        cmp("sw_busy_cycles", 32'(busy_cyc - b0), 32'd3);
        b0 = busy_cyc;
        acc(1, 0, 3'd2, 32'h10, 32'h0);
        cmp("lw_10", DATA_MEM_READ_DATA, 32'hDEADBEEF);
        cmp("lw_busy_cycles", 32'(busy_cyc - b0), 32'd3);
        acc(0, 1, 3'd2, 32'h20, 32'h000080F0);
        acc(1, 0, 3'd0, 32'h20, 32'h0);
        cmp("lb_20", DATA_MEM_READ_DATA, 32'hFFFFFFF0);
        acc(1, 0, 3'd4, 32'h20, 32'h0);
        cmp("lbu_20", DATA_MEM_READ_DATA, 32'h000000F0);
        acc(1, 0, 3'd0, 32'h21, 32'h0);
        cmp("lb_21", DATA_MEM_READ_DATA, 32'hFFFFFF80);
        acc(1, 0, 3'd1, 32'h20, 32'h0);
        cmp("lh_20", DATA_MEM_READ_DATA, 32'hFFFF80F0);
        acc(1, 0, 3'd5, 32'h20, 32'h0);
        cmp("lhu_20", DATA_MEM_READ_DATA, 32'h000080F0);
        acc(0, 1, 3'd2, 32'h30, 32'h11223344);
        acc(0, 1, 3'd0, 32'h32, 32'h000000AA);
        acc(0, 1, 3'd1, 32'h30, 32'h0000BBCC);
        acc(1, 0, 3'd2, 32'h30, 32'h0);
        cmp("partial_lw_30", DATA_MEM_READ_DATA, 32'h11AABBCC);
        b0 = mis_cyc;
        acc(1, 0, 3'd2, 32'h31, 32'h0);
        cmp("mis_lw_31", DATA_MEM_READ_DATA, 32'h0);
        cmp("mis_pulse_cycles", 32'(mis_cyc - b0), 32'd1);
        acc(0, 1, 3'd2, 32'h32, 32'h5);
        acc(1, 0, 3'd2, 32'h30, 32'h0);
        cmp("mis_sw_unchanged", DATA_MEM_READ_DATA, 32'h11AABBCC);
        acc(1, 0, 3'd1, 32'h33, 32'h0);
        acc(1, 0, 3'd0, 32'h33, 32'h0);
        cmp("lb_33", DATA_MEM_READ_DATA, 32'h00000011);
        b0 = mis_cyc;
        acc(1, 0, 3'd3, 32'h30, 32'h0);
        cmp("undef_read", DATA_MEM_READ_DATA, 32'h0);
        acc(0, 1, 3'd3, 32'h30, 32'h0);
        cmp("undef_no_mis", 32'(mis_cyc - b0), 32'd0);
        acc(1, 0, 3'd2, 32'h30, 32'h0);
        cmp("undef_write_no_store", DATA_MEM_READ_DATA, 32'h11AABBCC);
        acc(1, 1, 3'd2, 32'h50, 32'hCAFEF00D);
        cmp("rw_keeps_rdata", DATA_MEM_READ_DATA, 32'h11AABBCC);
        acc(1, 0, 3'd2, 32'h50, 32'h0);
        cmp("rw_as_write", DATA_MEM_READ_DATA, 32'hCAFEF00D);
        acc(0, 1, 3'd2, 32'h40, 32'h0);
        DATA_MEM_WRITE = 3'b110;
        DATA_MEM_ADDR = 32'h40;
        DATA_MEM_WRITE_DATA = 32'h12345678;
        exp_busy = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        DATA_MEM_WRITE = 3'd0;
        exp_busy = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_rdata = 32'd0;
        cmp("reset_rdata", DATA_MEM_READ_DATA, 32'h0);
        @(posedge CLK); #1;
        acc(0, 1, 3'd2, 32'h30, 32'h0);
        acc(1, 0, 3'd2, 32'h40, 32'h0);
        cmp("reset_abort_lw_40", DATA_MEM_READ_DATA, 32'h0);
        acc(0, 1, 3'd2, 32'h40 + 4 * (2 ** AW), 32'h77);
        b0 = bursts;
        acc(1, 0, 3'd2, 32'h40, 32'h0);
        cmp("wrap_lw_40", DATA_MEM_READ_DATA, 32'h77);
        cmp("held_one_burst", 32'(bursts - b0), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; storage is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter ACCESS_LATENCY, default 3, BUSYWAIT-high cycles per access; legal range 2..15.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 DATA_MEM_READ  input  4  bit3 = read request; bits2:0 = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 DATA_MEM_WRITE  input  3  bit2 = write request; bits1:0 = funct3 (00 SB, 01 SH, 10 SW).
REQ-007 DATA_MEM_ADDR  input  32  byte address.
REQ-008 DATA_MEM_WRITE_DATA  input  32  store data; SB uses bits 7:0, SH uses bits 15:0.
REQ-009 DATA_MEM_READ_DATA  output  32  registered load result, extended per funct3.
REQ-010 DATA_MEM_BUSYWAIT  output  1  high while an access is in progress; the initiator stalls while high.
REQ-011 MISALIGNED  output  1  one-cycle pulse flagging an aborted misaligned access.

Function
REQ-012 Request present = DATA_MEM_READ[3] | DATA_MEM_WRITE[2].
REQ-013 FSM states: IDLE, ACCESS, DONE.
REQ-014 IDLE with request present: BUSYWAIT = 1 combinationally in the same cycle.
REQ-015 IDLE with request present, at the rising edge: latch op, funct3, address and write data; load counter with ACCESS_LATENCY-2; go to ACCESS.
REQ-016 ACCESS: BUSYWAIT = 1; counter decrements each cycle.
REQ-017 ACCESS with counter == 0, at the rising edge: commit the access; go to DONE.
REQ-018 BUSYWAIT is therefore high for exactly ACCESS_LATENCY consecutive cycles per access.
REQ-019 DONE: BUSYWAIT = 0 for one cycle; unconditionally return to IDLE at the next edge.
REQ-020 DONE: a request still present is the completed one and is not re-executed.
REQ-021 Input changes during ACCESS are ignored; only the latched values are used.
REQ-022 Read and write both requested: treat as write; READ_DATA unchanged.
REQ-023 Word index = latched ADDR[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
REQ-024 Byte lane = ADDR[1:0]; little-endian byte order within each word.
REQ-025 SB: write only the addressed byte lane.
REQ-026 SH: write lanes 1:0 or 3:2, selected by ADDR[1].
REQ-027 SW: write the full word.
REQ-028 LB/LH: sign-extend the addressed byte or half to 32 bits.
REQ-029 LBU/LHU: zero-extend the addressed byte or half to 32 bits.
REQ-030 LW: return the full word.
REQ-031 Reads: DATA_MEM_READ_DATA updates at the commit edge, is valid in DONE, and holds until the next committed read.
REQ-032 Misaligned = halfword with ADDR[0]=1, or word with ADDR[1:0]≠00.
REQ-033 Misaligned access still takes the full latency, but at the commit edge: no storage write; READ_DATA = 0 for a read; MISALIGNED = 1 during DONE only.
REQ-034 Undefined funct3 (read 011/11x, write 11): complete with normal latency, no write, READ_DATA = 0; MISALIGNED stays 0.
REQ-035 At most one access is outstanding at any time.

Reset
REQ-036 RESET at any edge: state IDLE, counter 0, DATA_MEM_READ_DATA = 0, MISALIGNED = 0.
REQ-037 While RESET is high, BUSYWAIT = 0 regardless of the request inputs.
REQ-038 RESET during ACCESS aborts the access; no storage write occurs.
REQ-039 Storage contents are not cleared by RESET.

Verification
REQ-040 Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> BUSYWAIT high 3 cycles per access; READ_DATA = 0xDEADBEEF in DONE.
REQ-041 Byte/half extension: after SW 0x000080F0 @0x20 -> LB @0x20 = 0xFFFFFFF0; LBU @0x20 = 0x000000F0; LB @0x21 = 0xFFFFFF80; LH @0x20 = 0xFFFF80F0; LHU @0x20 = 0x000080F0.
REQ-042 Partial store: SW 0x11223344 @0x30, SB 0xAA @0x32, SH 0xBBCC @0x30, then LW @0x30 -> 0x11AABBCC.
REQ-043 Misaligned: LW @0x31 -> READ_DATA = 0 and MISALIGNED pulses 1 cycle; SW 0x5 @0x32 -> word @0x30 unchanged.
REQ-044 Reset mid-access: SW 0x12345678 @0x40 preceded by SW 0 @0x40, RESET in ACCESS cycle 1 -> BUSYWAIT = 0 next cycle; LW @0x40 later returns 0.
REQ-045 Wrap and held request: SW 0x77 @(0x40+4·2^ADDR_WIDTH) -> LW @0x40 = 0x77; a request held through DONE executes exactly once (one BUSYWAIT burst).
